// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache with 4-word (128-bit) lines.
// Hits return the word combinationally; misses stall the core, fetch the line
// through a request/ready handshake and then replay the lookup.
// Optional macro ICACHE_PERF_EN adds the hit_cnt / miss_cnt performance counters.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | serve hits, detect misses and latch the line address
//   S_FETCH | hold mem_read until mem_ready, then install the line
module icache_dm #(
    parameter int NUM_BLOCKS = 8,
    parameter int ADDR_W     = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              proc_read,
    input  logic [ADDR_W-1:0] proc_addr,
    output logic [31:0]       proc_rdata,
    output logic              proc_stall,
    output logic              mem_read,
    output logic [ADDR_W-3:0] mem_addr,
    input  logic [127:0]      mem_rdata,
    input  logic              mem_ready
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);
    localparam int IDX_W = $clog2(NUM_BLOCKS);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    typedef enum logic {S_IDLE, S_FETCH} state_t;

    state_t             state_r, state_nx;
    logic [NUM_BLOCKS-1:0] valid_r;
    logic [TAG_W-1:0]   tag_r  [NUM_BLOCKS];
    logic [127:0]       data_r [NUM_BLOCKS];
    logic [ADDR_W-3:0]  miss_addr_r;

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   addr_tag;
    logic [1:0]         offset;
    logic               hit;
    logic               miss_det;
    logic               fill;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   fill_tag;

    assign idx      = proc_addr[IDX_W+1:2];
    assign addr_tag = proc_addr[ADDR_W-1:IDX_W+2];
    assign offset   = proc_addr[1:0];
    assign hit      = valid_r[idx] && (tag_r[idx] == addr_tag);
    assign fill_idx = miss_addr_r[IDX_W-1:0];
    assign fill_tag = miss_addr_r[ADDR_W-3:IDX_W];

    // Indexed word is driven unconditionally; the core qualifies it with stall.
    assign proc_rdata = data_r[idx][{offset, 5'b00000} +: 32];
    assign mem_addr   = miss_addr_r;

    // State register with synchronous reset; reset aborts an in-flight fetch.
    always_ff @(posedge clk) begin
        if (!rst_n) state_r <= S_IDLE;
        else        state_r <= state_nx;
    end

    // Next-state and handshake/stall decode.
    always_comb begin
        state_nx   = state_r;
        proc_stall = 1'b0;
        mem_read   = 1'b0;
        miss_det   = 1'b0;
        fill       = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (proc_read && !hit) begin
                    proc_stall = 1'b1;
                    miss_det   = 1'b1;
                    state_nx   = S_FETCH;
                end
            end
            S_FETCH: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                if (mem_ready) begin
                    fill     = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Miss line address and valid bits; a fill coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            miss_addr_r <= '0;
            valid_r     <= '0;
        end else begin
            if (miss_det) miss_addr_r <= proc_addr[ADDR_W-1:2];
            if (fill)     valid_r[fill_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid qualifies them.
    always_ff @(posedge clk) begin
        if (rst_n && fill) begin
            tag_r[fill_idx]  <= fill_tag;
            data_r[fill_idx] <= mem_rdata;
        end
    end

`ifdef ICACHE_PERF_EN
    // Free-running hit/miss counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (state_r == S_IDLE && proc_read && hit) hit_cnt <= hit_cnt + 32'd1;
            if (miss_det) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped, read-only instruction cache between the core's instruction-fetch port and the slow instruction memory. Hits return the 32-bit instruction word combinationally in the same cycle. A miss stalls the core, fetches a 128-bit line through a request/ready handshake, then replays the lookup. The cache passes words through unmodified, so memory byte order is preserved for the core's own byte swap.

## Interface
- `NUM_BLOCKS`, default 8: number of cache lines; power of two, ≥2. `IDX_W = log2(NUM_BLOCKS)`.
- `ADDR_W`, default 30: width of the processor word address.
- Tag width: `TAG_W = ADDR_W - 2 - IDX_W`. Each line is 4 words / 128 bits.
- Clock and reset (already decided): reset `rst_n`, synchronous, active-low; clock `clk`.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous active-low reset.
- `proc_read` input 1: fetch request, sampled every cycle.
- `proc_addr` input ADDR_W: word address. `[1:0]` = word offset, `[IDX_W+1:2]` = index, upper bits = tag.
- `proc_rdata` output 32: instruction word. Valid when `proc_read` is 1 and `proc_stall` is 0.
- `proc_stall` output 1: high while the requested word is unavailable.
- `mem_read` output 1: line fetch request.
- `mem_addr` output ADDR_W-2: line address (`proc_addr[ADDR_W-1:2]` of the missing line).
- `mem_rdata` input 128: line data. Word 0 is in `[31:0]` and word 3 is in `[127:96]`.
- `mem_ready` input 1: one-cycle pulse; `mem_rdata` is valid in that cycle.
- `hit_cnt` output 32, `miss_cnt` output 32: present only with `ICACHE_PERF_EN`.

## Operation
- **Storage.** Per line: `valid` (1 bit), `tag` (TAG_W bits), `data` (128 bits). Only `valid` is reset.
- **Lookup.** The request is a hit when `valid[idx]` is set and `tag[idx] == addr_tag`. It is evaluated combinationally from `proc_addr`.
- **FSM states.**
  - `S_IDLE`: serves hits.
    - `proc_read` = 1 and hit: `proc_stall` = 0, `proc_rdata` = `data[idx]` word at the offset, stay in `S_IDLE`.
    - `proc_read` = 1 and miss: `proc_stall` = 1, latch the line address into `miss_addr_r`, go to `S_FETCH`.
    - `proc_read` = 0: `proc_stall` = 0, stay in `S_IDLE`.
  - `S_FETCH`: `mem_read` = 1, `mem_addr` = `miss_addr_r`, `proc_stall` = 1.
    - On a cycle with `mem_ready` = 1, at that edge write `data[idx]` = `mem_rdata`, write `tag[idx]`, set `valid[idx]` = 1, and go to `S_IDLE`.
    - Otherwise hold all outputs.
  - After `S_FETCH` returns to `S_IDLE`, the same address is looked up again and is a hit. No bypass forwarding.
- **Replacement.** Direct-mapped: a fill overwrites the line at `idx` unconditionally. There is no dirty state and no write path.
- **Outputs in idle.** `proc_rdata` is don't-care when `proc_stall` = 1 or `proc_read` = 0. Drive it as the indexed word anyway; it is not gated.
- **Core address behaviour.** The core must hold `proc_addr` while stalled. The cache uses `miss_addr_r`, so an address change during `S_FETCH` does not corrupt the fill; the replay cycle uses the new address.
- **`mem_ready` outside `S_FETCH`.** Ignored.

## Timing
- Hit latency: 0 cycles; data is combinational from `proc_addr`.
- Miss penalty: 1 (detect) + N (cycles in `S_FETCH` up to and including the `mem_ready` cycle) + 1 (replay hit).
  - With `mem_ready` arriving in the first `S_FETCH` cycle, the minimum penalty is 2 stall cycles; the data returns in cycle 3.
- `mem_read` is registered-state driven: it rises the cycle after miss detection and falls the cycle after `mem_ready`.
- **Reset values.** All `valid` = 0, state = `S_IDLE`, `mem_read` = 0, `mem_addr` = 0, `miss_addr_r` = 0. `proc_stall` = `proc_read` (every lookup misses). Counters = 0.
- **Reset during `S_FETCH`.**
  - Abort to `S_IDLE`, `mem_read` = 0.
  - A `mem_ready` in the reset cycle is discarded and no line is written.

## Configuration
- Macro: `ICACHE_PERF_EN`.
- **Defined.**
  - Ports `hit_cnt` and `miss_cnt` exist.
  - `hit_cnt` increments on each `S_IDLE` cycle with `proc_read` = 1 and a hit.
  - `miss_cnt` increments on each `S_IDLE` to `S_FETCH` transition.
  - Both counters wrap modulo 2^32 and are cleared by reset.
- **Undefined.** The ports and counter logic are absent; all other behaviour is identical.

## Test plan
- **Cold miss.**
  - Stimulus: after reset, `proc_read` = 1, `proc_addr` = 0x10; memory returns `mem_ready` 3 cycles after `mem_read` rises, with `mem_rdata` = {0xDDDD0003, 0xCCCC0002, 0xBBBB0001, 0xAAAA0000}.
  - Required: `mem_addr` = 0x4 and `proc_stall` high for 5 cycles, then `proc_rdata` = 0xAAAA0000 with stall low.
- **Same-line hits.** Stimulus: after the cold-miss fill, `proc_addr` = 0x11, 0x12, 0x13 on consecutive cycles. Required: zero stalls; `proc_rdata` = 0xBBBB0001, 0xCCCC0002, 0xDDDD0003; `mem_read` stays 0.
- **Conflict eviction** (`NUM_BLOCKS` = 8).
  - Stimulus: fill address 0x10, then read 0x30 (same index 4, different tag), then read 0x10 again.
  - Required: each of the three accesses misses and issues `mem_read`, with `mem_addr` = 0x4, 0xC, 0x4 respectively.
- **Zero-wait memory.** Stimulus: assert `mem_ready` in the first `S_FETCH` cycle. Required: exactly 2 stall cycles; correct word in the third cycle.
- **Reset mid-fill.**
  - Stimulus: assert `rst_n` = 0 while in `S_FETCH`, with `mem_ready` = 1 in the same cycle; then release reset and re-read the same address.
  - Required: `mem_read` = 0 after the reset edge, and the re-read misses again (line not installed).
- **Counters** (`ICACHE_PERF_EN` defined). Stimulus: the cold-miss and same-line-hits sequences. Required: `miss_cnt` = 1 and `hit_cnt` = 4, the replay hit included.
